icache_ctrl_param: RTL and testbench

//  Parametrised direct-mapped instruction cache, successor to the fixed 256x128b icache.

---
 rtl/icache_ctrl_param_if.sv | 29 ++
 rtl/icache_ctrl_param.sv | 155 +++++++++++++++
 tb/tb_icache_ctrl_param.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_ctrl_param_if.sv
// Fetch, flush and line-refill signals shared by icache_ctrl_param and its neighbours.
interface icache_ctrl_param_if #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4
);
    localparam int LINE_AW = ADDR_W - $clog2(LINE_WORDS) - 2;

    logic               if_req;
    logic [ADDR_W-1:0]  if_addr;
    logic [31:0]        if_data;
    logic               if_ready;
    logic               miss_stall;
    logic               flush;
    logic               flush_busy;
    logic               mem_req;
    logic [LINE_AW-1:0] mem_addr;
    logic               mem_rvalid;
    logic [31:0]        mem_rdata;

    modport master (
        output if_req, if_addr, flush, mem_rvalid, mem_rdata,
        input  if_data, if_ready, miss_stall, flush_busy, mem_req, mem_addr
    );

    modport slave (
        input  if_req, if_addr, flush, mem_rvalid, mem_rdata,
        output if_data, if_ready, miss_stall, flush_busy, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_ctrl_param.sv
// Direct-mapped I-cache with burst refill and flush sweep; ICACHE_PERF_EN adds hit/miss counters.
// Hits return in the same cycle; misses and flushes hold miss_stall until the line or sweep completes.
module icache_ctrl_param #(
    parameter int ADDR_W     = 32,
    parameter int INDEX_W    = 8,
    parameter int LINE_WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    icache_ctrl_param_if.slave bus
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
`endif
);
    localparam int OFFSET_W = $clog2(LINE_WORDS);
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W - 2;
    localparam int LINE_AW  = ADDR_W - OFFSET_W - 2;
    localparam int LINES    = 1 << INDEX_W;
    localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_FLUSH} state_t;

    state_t              state_q, state_d;
    logic [LINE_AW-1:0]  line_q, line_d;
    logic [OFFSET_W-1:0] beat_cnt_q, beat_cnt_d;
    logic                flush_pend_q, flush_pend_d;
    logic [INDEX_W-1:0]  sweep_idx_q, sweep_idx_d;
    logic [LINES-1:0]    valid_q, valid_d;

    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [31:0]         data_mem [LINES][LINE_WORDS];

    logic [OFFSET_W-1:0] req_off;
    logic [INDEX_W-1:0]  req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  fill_idx;
    logic                lookup_hit, serve, hit, miss, fill_wr, fill_last;
    logic                unused_addr_lsb;

    assign req_off         = bus.if_addr[OFFSET_W+1:2];
    assign req_idx         = bus.if_addr[OFFSET_W+2 +: INDEX_W];
    assign req_tag         = bus.if_addr[ADDR_W-1 -: TAG_W];
    assign fill_idx        = line_q[INDEX_W-1:0];
    assign unused_addr_lsb = ^bus.if_addr[1:0];

    // A flush in IDLE wins over a same-cycle fetch: nothing is served or refilled.
    assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign serve      = (state_q == S_IDLE) && bus.if_req && !bus.flush;
    assign hit        = serve && lookup_hit;
    assign miss       = serve && !lookup_hit;
    assign fill_wr    = (state_q == S_REFILL) && bus.mem_rvalid;
    assign fill_last  = fill_wr && (beat_cnt_q == LAST_BEAT);

    assign bus.if_ready   = hit;
    assign bus.if_data    = hit ? data_mem[req_idx][req_off] : 32'h0;
    assign bus.miss_stall = (state_q != S_IDLE) || (bus.if_req && !hit);
    assign bus.flush_busy = (state_q == S_FLUSH);
    assign bus.mem_req    = (state_q == S_REFILL);
    assign bus.mem_addr   = line_q;

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        beat_cnt_d   = beat_cnt_q;
        flush_pend_d = flush_pend_q;
        sweep_idx_d  = sweep_idx_q;
        valid_d      = valid_q;
        case (state_q)
            S_IDLE: begin
                if (bus.flush) begin
                    state_d     = S_FLUSH;
                    sweep_idx_d = '0;
                end else if (miss) begin
                    line_d     = bus.if_addr[ADDR_W-1:OFFSET_W+2];
                    beat_cnt_d = '0;
                    state_d    = S_REFILL;
                end
            end
            S_REFILL: begin
                if (bus.flush) flush_pend_d = 1'b1;
                if (fill_wr) begin
                    // Line stays invalid while partially written; only the last beat validates it.
                    valid_d[fill_idx] = fill_last;
                    beat_cnt_d        = beat_cnt_q + OFFSET_W'(1);
                    if (fill_last) begin
                        if (flush_pend_q || bus.flush) begin
                            state_d     = S_FLUSH;
                            sweep_idx_d = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_FLUSH: begin
                valid_d[sweep_idx_q] = 1'b0;
                sweep_idx_d          = sweep_idx_q + INDEX_W'(1);
                if (&sweep_idx_q) begin
                    state_d      = S_IDLE;
                    flush_pend_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            line_q       <= '0;
            beat_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            sweep_idx_q  <= '0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            beat_cnt_q   <= beat_cnt_d;
            flush_pend_q <= flush_pend_d;
            sweep_idx_q  <= sweep_idx_d;
            valid_q      <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_wr)   data_mem[fill_idx][beat_cnt_q] <= bus.mem_rdata;
        if (fill_last) tag_mem[fill_idx] <= line_q[LINE_AW-1:INDEX_W];
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_d  = hit_cnt_q + 32'd1;
        if (miss && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_d = miss_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache_ctrl_param.sv
// Randomised bench for icache_ctrl_param against an array-based cache model.
module tb_icache_ctrl_param;
    localparam int ADDR_W     = 32;
    localparam int INDEX_W    = 8;
    localparam int LINE_WORDS = 4;
    localparam int LINES      = 1 << INDEX_W;
    localparam int LINE_AW    = ADDR_W - 2 - 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    icache_ctrl_param_if #(.ADDR_W(ADDR_W), .LINE_WORDS(LINE_WORDS)) bus();
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    icache_ctrl_param #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .LINE_WORDS(LINE_WORDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus)
`ifdef ICACHE_PERF_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    // Reference model: one entry per line, addressed by plain address arithmetic.
    bit          mvalid [LINES];
    int unsigned mtag   [LINES];
    logic [31:0] mdata  [LINES][LINE_WORDS];
    int total = 0;
    int bad   = 0;
    int exp_hits   = 0;
    int exp_misses = 0;

    function automatic int unsigned idx_of(input logic [31:0] a);
        int unsigned au = a;
        return (au / (4 * LINE_WORDS)) % LINES;
    endfunction
    function automatic int unsigned off_of(input logic [31:0] a);
        int unsigned au = a;
        return (au / 4) % LINE_WORDS;
    endfunction
    function automatic int unsigned tag_of(input logic [31:0] a);
        int unsigned au = a;
        return au / (4 * LINE_WORDS * LINES);
    endfunction
    function automatic bit m_hit(input logic [31:0] a);
        return mvalid[idx_of(a)] && (mtag[idx_of(a)] == tag_of(a));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear_all();
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.flush = 1'b0;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        tick();
        rst = 1'b0;
        model_clear_all();
        exp_hits = 0; exp_misses = 0;
    endtask

    task automatic count_busy(input int pulse_at, output int n);
        n = 0;
        while (bus.flush_busy === 1'b1 && n < 1000) begin
            n++;
            bus.flush = (n == pulse_at);
            tick();
        end
        bus.flush = 1'b0;
    endtask

    // One fetch; on a miss drives the refill, optionally with a flush or reset at a given beat.
    task automatic access(input logic [31:0] a, input bit fixed, input logic [31:0] base,
                          input int flush_at, input int rst_at);
        logic [31:0] d;
        int gaps, n;
        bit aborted;
        aborted = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = a; bus.flush = 1'b0;
        if (m_hit(a)) begin
            bus.mem_rvalid = 1'($urandom_range(0, 1));
            bus.mem_rdata  = $urandom;
            #1;
            total++;
            if (bus.if_ready !== 1'b1 || bus.if_data !== mdata[idx_of(a)][off_of(a)]) begin
                bad++;
                $display("FAIL hit_data addr=%h got ready=%b data=%h want ready=1 data=%h",
                         a, bus.if_ready, bus.if_data, mdata[idx_of(a)][off_of(a)]);
            end
            total++;
            if (bus.mem_req !== 1'b0) begin
                bad++; $display("FAIL hit_no_req addr=%h got mem_req=%b want 0", a, bus.mem_req);
            end
            exp_hits++;
            tick();
        end else begin
            bus.mem_rvalid = 1'b0;
            #1;
            total++;
            if (bus.if_ready !== 1'b0 || bus.miss_stall !== 1'b1) begin
                bad++;
                $display("FAIL miss_detect addr=%h got ready=%b stall=%b want ready=0 stall=1",
                         a, bus.if_ready, bus.miss_stall);
            end
            exp_misses++;
            tick();
            total++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== LINE_AW'(a / (4 * LINE_WORDS))) begin
                bad++;
                $display("FAIL refill_req addr=%h got req=%b mem_addr=%h want req=1 mem_addr=%h",
                         a, bus.mem_req, bus.mem_addr, LINE_AW'(a / (4 * LINE_WORDS)));
            end
            for (int b = 0; b < LINE_WORDS; b++) begin
                if (!aborted) begin
                    gaps = fixed ? 0 : $urandom_range(0, 2);
                    for (int g = 0; g < gaps; g++) begin
                        bus.mem_rvalid = 1'b0; bus.flush = 1'b0; bus.if_addr = $urandom;
                        #1;
                        total++;
                        if (bus.mem_req !== 1'b1 || bus.miss_stall !== 1'b1 || bus.if_ready !== 1'b0 ||
                            bus.mem_addr !== LINE_AW'(a / (4 * LINE_WORDS))) begin
                            bad++;
                            $display("FAIL refill_hold got req=%b stall=%b ready=%b mem_addr=%h want 1 1 0 %h",
                                     bus.mem_req, bus.miss_stall, bus.if_ready, bus.mem_addr,
                                     LINE_AW'(a / (4 * LINE_WORDS)));
                        end
                        tick();
                    end
                    d = fixed ? base + 32'(b) : $urandom;
                    bus.mem_rvalid = 1'b1; bus.mem_rdata = d; bus.flush = (b == flush_at);
                    if (b == rst_at) begin
                        rst = 1'b1;
                        tick();
                        rst = 1'b0;
                        aborted = 1'b1;
                        model_clear_all();
                        exp_hits = 0; exp_misses = 0;
                    end else begin
                        mdata[idx_of(a)][b] = d;
                        tick();
                    end
                end
            end
            bus.mem_rvalid = 1'b0; bus.flush = 1'b0;
            if (aborted) begin
                bus.if_req = 1'b0;
                #1;
                total++;
                if (bus.mem_req !== 1'b0 || bus.miss_stall !== 1'b0) begin
                    bad++;
                    $display("FAIL rst_abort got req=%b stall=%b want 0 0", bus.mem_req, bus.miss_stall);
                end
                for (int s = 0; s < 3; s++) begin
                    bus.mem_rvalid = 1'b1; bus.mem_rdata = $urandom;
                    tick();
                    total++;
                    if (bus.mem_req !== 1'b0) begin
                        bad++; $display("FAIL stray_beat got mem_req=%b want 0", bus.mem_req);
                    end
                end
                bus.mem_rvalid = 1'b0;
            end else begin
                bus.if_addr = a;
                mvalid[idx_of(a)] = 1'b1;
                mtag[idx_of(a)]   = tag_of(a);
                #1;
                if (flush_at >= 0) begin
                    total++;
                    if (bus.flush_busy !== 1'b1 || bus.if_ready !== 1'b0) begin
                        bad++;
                        $display("FAIL pend_flush got busy=%b ready=%b want 1 0", bus.flush_busy, bus.if_ready);
                    end
                    bus.if_req = 1'b0;
                    count_busy(-1, n);
                    total++;
                    if (n != LINES) begin
                        bad++; $display("FAIL pend_sweep_len got %0d want %0d", n, LINES);
                    end
                    model_clear_all();
                end else begin
                    total++;
                    if (bus.if_ready !== 1'b1 || bus.if_data !== mdata[idx_of(a)][off_of(a)] ||
                        bus.mem_req !== 1'b0) begin
                        bad++;
                        $display("FAIL refill_hit addr=%h got ready=%b data=%h req=%b want 1 %h 0",
                                 a, bus.if_ready, bus.if_data, bus.mem_req, mdata[idx_of(a)][off_of(a)]);
                    end
                    exp_hits++;
                    tick();
                end
            end
        end
        bus.if_req = 1'b0; bus.mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (bus.if_data !== 32'h0 || bus.if_ready !== 1'b0 || bus.miss_stall !== 1'b0 ||
            bus.flush_busy !== 1'b0 || bus.mem_req !== 1'b0 || bus.mem_addr !== '0) begin
            bad++;
            $display("FAIL reset_outputs got data=%h ready=%b stall=%b busy=%b req=%b addr=%h want all 0",
                     bus.if_data, bus.if_ready, bus.miss_stall, bus.flush_busy, bus.mem_req, bus.mem_addr);
        end
`ifdef ICACHE_PERF_EN
        total++;
        if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            bad++; $display("FAIL reset_perf got hit=%0d miss=%0d want 0 0", hit_cnt, miss_cnt);
        end
`endif
        tick();
    endtask

    task automatic test_cold_miss();
        access(32'h0000_1230, 1'b1, 32'hA0, -1, -1);
    endtask

    task automatic test_hit();
        access(32'h0000_1234, 1'b1, 32'h0, -1, -1);
        access(32'h0000_123C, 1'b1, 32'h0, -1, -1);
    endtask

    task automatic test_conflict();
        access(32'h0010_1230, 1'b1, 32'hB0, -1, -1);
        access(32'h0000_1230, 1'b1, 32'hA0, -1, -1);
        access(32'h0000_1238, 1'b1, 32'h0, -1, -1);
    endtask

    task automatic test_random();
        logic [31:0] a;
        int unsigned idx_pool [4];
        idx_pool[0] = 8'h23; idx_pool[1] = 8'h24; idx_pool[2] = 8'hFF; idx_pool[3] = 8'h00;
        for (int i = 0; i < 40; i++) begin
            a = (32'($urandom_range(0, 2)) << 12) | (32'(idx_pool[$urandom_range(0, 3)]) << 4) |
                (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            access(a, 1'b0, 32'h0, -1, -1);
            if ($urandom_range(0, 1) == 1) tick();
        end
    endtask

    task automatic test_flush();
        int n;
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_1234; bus.flush = 1'b1;
        #1;
        total++;
        if (bus.if_ready !== 1'b0) begin
            bad++; $display("FAIL flush_prio got if_ready=%b want 0", bus.if_ready);
        end
        tick();
        bus.flush = 1'b0; bus.if_req = 1'b0;
        count_busy(100, n);
        total++;
        if (n != LINES) begin
            bad++; $display("FAIL flush_len got %0d want %0d", n, LINES);
        end
        model_clear_all();
        access(32'h0000_1230, 1'b0, 32'h0, -1, -1);
        access(32'h0000_1230, 1'b0, 32'h0, -1, -1);
    endtask

    task automatic test_flush_during_refill();
        access(32'h0020_1240, 1'b0, 32'h0, 2, -1);
        access(32'h0000_1230, 1'b0, 32'h0, -1, -1);
        access(32'h0020_1244, 1'b0, 32'h0, -1, -1);
    endtask

    task automatic test_reset_abort();
        do_reset();
        access(32'h0000_1230, 1'b0, 32'h0, -1, 1);
        access(32'h0000_1230, 1'b0, 32'h0, -1, -1);
        access(32'h0000_1234, 1'b0, 32'h0, -1, -1);
    endtask

    task automatic test_perf();
`ifdef ICACHE_PERF_EN
        #1;
        total++;
        if (hit_cnt !== 32'(exp_hits) || miss_cnt !== 32'(exp_misses)) begin
            bad++;
            $display("FAIL perf_counts got hit=%0d miss=%0d want %0d %0d",
                     hit_cnt, miss_cnt, exp_hits, exp_misses);
        end
`endif
        tick();
    endtask

    initial begin
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.flush = 1'b0;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        tick();
        do_reset();
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_random();
        test_flush();
        test_flush_during_refill();
        test_reset_abort();
        test_perf();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
